// File: rtl/sn74169_pkg.sv
// Shared encodings for the SN74169 counter controller: command opcodes,
// controller state codes and the 4-bit wrap-around step used by the shadow.
package sn74169_pkg;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_UP   = 2'b01;
    localparam logic [1:0] OP_DOWN = 2'b10;
    localparam logic [1:0] OP_HOLD = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_LOAD = 2'b01;
    localparam logic [1:0] ST_RUN  = 2'b10;

    // Mirrors one enabled clock of the 74169: modulo-16 in either direction.
    function automatic logic [3:0] step4(input logic [3:0] value, input logic up);
        return up ? value + 4'd1 : value - 4'd1;
    endfunction

endpackage

// File: rtl/sn74169_shadow.sv
// Shadow copy of the external 74169: follows the registered control pins and
// predicts the counter value (EXP) and its terminal-count output (TC).
module sn74169_shadow
    import sn74169_pkg::*;
(
    input  logic       CLK,
    input  logic       RSTB,
    input  logic       LOADB,
    input  logic       ENPB,
    input  logic       ENTB,
    input  logic       U_DB,
    input  logic [3:0] A,
    output logic [3:0] EXP,
    output logic       TC,
    output logic       exp_valid
);

    // Load has priority over counting, exactly as on the real part.
    always_ff @(posedge CLK) begin
        if (!RSTB) begin
            EXP       <= 4'd0;
            exp_valid <= 1'b0;
        end else if (!LOADB) begin
            EXP       <= A;
            exp_valid <= 1'b1;
        end else if (!ENPB && !ENTB) begin
            EXP <= step4(EXP, U_DB);
        end
    end

    assign TC = !ENTB && (U_DB ? (EXP == 4'hF) : (EXP == 4'h0));

endmodule

// File: rtl/sn74169_ctrl.sv
// Command-driven controller for an SN74169 4-bit up/down counter, with a
// shadow model of the counter and a sticky read-back mismatch flag.
module sn74169_ctrl
    import sn74169_pkg::*;
#(
    parameter int LEN_W = 8
) (
    input  logic             CLK,
    input  logic             RSTB,
    input  logic             CMD_VALID,
    output logic             CMD_READY,
    input  logic [1:0]       CMD_OP,
    input  logic [3:0]       CMD_DATA,
    input  logic [LEN_W-1:0] CMD_LEN,
    output logic [3:0]       A,
    output logic             LOADB,
    output logic             ENPB,
    output logic             ENTB,
    output logic             U_DB,
    input  logic [3:0]       Q,
    output logic             DONE,
    output logic [3:0]       EXP,
    output logic             TC,
    output logic             MISMATCH
);

    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
    localparam logic [LEN_W-1:0] LEN_ZERO = '0;

    logic [1:0]       state;
    logic [LEN_W-1:0] cycles_left;
    logic             exp_valid;
    logic             load_accept;

    assign CMD_READY   = (state == ST_IDLE);
    assign load_accept = CMD_VALID && CMD_READY && (CMD_OP == OP_LOAD);

    // A zero-length command still occupies one RUN cycle, just with enables off.
    always_ff @(posedge CLK) begin
        if (!RSTB) begin
            state       <= ST_IDLE;
            cycles_left <= LEN_ZERO;
            A           <= 4'd0;
            LOADB       <= 1'b1;
            ENPB        <= 1'b1;
            ENTB        <= 1'b1;
            U_DB        <= 1'b1;
            DONE        <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (CMD_VALID) begin
                        if (CMD_OP == OP_LOAD) begin
                            state <= ST_LOAD;
                            A     <= CMD_DATA;
                            LOADB <= 1'b0;
                        end else begin
                            state <= ST_RUN;
                            if (CMD_LEN == LEN_ZERO) begin
                                cycles_left <= LEN_ONE;
                            end else begin
                                cycles_left <= CMD_LEN;
                                if (CMD_OP != OP_HOLD) begin
                                    ENPB <= 1'b0;
                                    ENTB <= 1'b0;
                                    U_DB <= (CMD_OP == OP_UP);
                                end
                            end
                        end
                    end
                end
                ST_LOAD: begin
                    state <= ST_IDLE;
                    LOADB <= 1'b1;
                    DONE  <= 1'b1;
                end
                ST_RUN: begin
                    if (cycles_left == LEN_ONE) begin
                        state       <= ST_IDLE;
                        cycles_left <= LEN_ZERO;
                        ENPB        <= 1'b1;
                        ENTB        <= 1'b1;
                        DONE        <= 1'b1;
                    end else begin
                        cycles_left <= cycles_left - LEN_ONE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    LOADB <= 1'b1;
                    ENPB  <= 1'b1;
                    ENTB  <= 1'b1;
                end
            endcase
        end
    end

    // A fresh mismatch outranks the clear that an accepted LOAD would cause.
    always_ff @(posedge CLK) begin
        if (!RSTB) begin
            MISMATCH <= 1'b0;
        end else if (exp_valid && (Q != EXP)) begin
            MISMATCH <= 1'b1;
        end else if (load_accept) begin
            MISMATCH <= 1'b0;
        end
    end

    sn74169_shadow u_shadow (
        .CLK       (CLK),
        .RSTB      (RSTB),
        .LOADB     (LOADB),
        .ENPB      (ENPB),
        .ENTB      (ENTB),
        .U_DB      (U_DB),
        .A         (A),
        .EXP       (EXP),
        .TC        (TC),
        .exp_valid (exp_valid)
    );

endmodule

// File: tb/tb_sn74169_ctrl.sv
// Self-checking bench for sn74169_ctrl: a behavioural 74169 drives Q back,
// commands are checked against a per-command arithmetic model.
module tb_sn74169_ctrl;

    localparam logic [1:0] OP_LD   = 2'b00;
    localparam logic [1:0] OP_UP   = 2'b01;
    localparam logic [1:0] OP_DN   = 2'b10;
    localparam logic [1:0] OP_HOLD = 2'b11;

    logic       CLK = 1'b0;
    logic       RSTB;
    logic       CMD_VALID;
    logic       CMD_READY;
    logic [1:0] CMD_OP;
    logic [3:0] CMD_DATA;
    logic [7:0] CMD_LEN;
    logic [3:0] A;
    logic       LOADB;
    logic       ENPB;
    logic       ENTB;
    logic       U_DB;
    logic [3:0] Q;
    logic       DONE;
    logic [3:0] EXP;
    logic       TC;
    logic       MISMATCH;

    int total = 0;
    int bad   = 0;

    int model_exp = 0;
    int model_a   = 0;

    logic [3:0] q_model   = 4'd0;
    logic       force_q   = 1'b0;
    logic [3:0] force_val = 4'd0;

    typedef struct {
        logic [1:0] op;
        logic [3:0] data;
        int         len;
        bit         junk;
        logic [3:0] exp_final;
    } vec_t;

    vec_t vecs[10];

    sn74169_ctrl #(.LEN_W(8)) dut (
        .CLK       (CLK),
        .RSTB      (RSTB),
        .CMD_VALID (CMD_VALID),
        .CMD_READY (CMD_READY),
        .CMD_OP    (CMD_OP),
        .CMD_DATA  (CMD_DATA),
        .CMD_LEN   (CMD_LEN),
        .A         (A),
        .LOADB     (LOADB),
        .ENPB      (ENPB),
        .ENTB      (ENTB),
        .U_DB      (U_DB),
        .Q         (Q),
        .DONE      (DONE),
        .EXP       (EXP),
        .TC        (TC),
        .MISMATCH  (MISMATCH)
    );

    always #5 CLK = ~CLK;

    // Behavioural SN74169 attached to the control pins; force_q fakes a faulty part.
    always @(posedge CLK) begin
        if (!LOADB)
            q_model <= A;
        else if (!ENPB && !ENTB)
            q_model <= U_DB ? q_model + 4'd1 : q_model - 4'd1;
    end
    assign Q = force_q ? force_val : q_model;

    task automatic check_output(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d required %0d", name, actual, expected);
        end
    endtask

    task automatic check_reset_values();
        check_output("rst_a",        int'(A), 0);
        check_output("rst_loadb",    int'(LOADB), 1);
        check_output("rst_enpb",     int'(ENPB), 1);
        check_output("rst_entb",     int'(ENTB), 1);
        check_output("rst_udb",      int'(U_DB), 1);
        check_output("rst_exp",      int'(EXP), 0);
        check_output("rst_tc",       int'(TC), 0);
        check_output("rst_done",     int'(DONE), 0);
        check_output("rst_mismatch", int'(MISMATCH), 0);
        check_output("rst_ready",    int'(CMD_READY), 1);
    endtask

    // Issues one command from an idle negedge and follows it to the cycle after DONE.
    task automatic apply_stimulus(input logic [1:0] op, input logic [3:0] data,
                                  input int len, input bit junk, input int exp_mm);
        int exp_busy, exp_en, exp_ld;
        int busy, en_cnt, ld_cnt, cur, tc_exp;
        bit stepping, up, got_done;
        stepping = ((op == OP_UP) || (op == OP_DN)) && (len > 0);
        up       = (op == OP_UP);
        exp_ld   = (op == OP_LD) ? 1 : 0;
        exp_busy = ((op == OP_LD) || (len == 0)) ? 1 : len;
        exp_en   = stepping ? len : 0;

        check_output("ready_idle", int'(CMD_READY), 1);
        CMD_VALID = 1'b1;
        CMD_OP    = op;
        CMD_DATA  = data;
        CMD_LEN   = 8'(len);
        @(negedge CLK);

        busy = 0; en_cnt = 0; ld_cnt = 0; got_done = 1'b0;
        for (int t = 0; t < exp_busy + 8; t++) begin
            if (DONE) begin
                got_done = 1'b1;
                break;
            end
            if (stepping)
                cur = up ? (model_exp + busy) % 16 : (((model_exp - busy) % 16) + 16) % 16;
            else
                cur = model_exp;
            tc_exp = (stepping && ((up && cur == 15) || (!up && cur == 0))) ? 1 : 0;
            check_output("exp_step", int'(EXP), cur);
            check_output("tc_step", int'(TC), tc_exp);
            check_output("mismatch_run", int'(MISMATCH), exp_mm);
            check_output("ready_busy", int'(CMD_READY), 0);
            if (!ENPB && !ENTB) en_cnt++;
            if (!LOADB) begin
                ld_cnt++;
                check_output("a_load", int'(A), int'(data));
            end
            busy++;
            if (junk) begin
                CMD_VALID = 1'b1;
                CMD_OP    = 2'($urandom_range(0, 3));
                CMD_DATA  = 4'($urandom);
                CMD_LEN   = 8'($urandom_range(0, 9));
            end else begin
                CMD_VALID = 1'b0;
            end
            @(negedge CLK);
        end
        CMD_VALID = 1'b0;

        check_output("done_seen", int'(got_done), 1);
        check_output("busy_cycles", busy, exp_busy);
        check_output("enable_cycles", en_cnt, exp_en);
        check_output("load_cycles", ld_cnt, exp_ld);
        check_output("ready_done", int'(CMD_READY), 1);

        if (op == OP_LD) begin
            model_exp = int'(data);
            model_a   = int'(data);
        end else if (stepping) begin
            model_exp = up ? (model_exp + len) % 16 : (((model_exp - len) % 16) + 16) % 16;
            check_output("udb_dir", int'(U_DB), up ? 1 : 0);
        end
        check_output("exp_done", int'(EXP), model_exp);
        check_output("a_hold", int'(A), model_a);
        check_output("mismatch_done", int'(MISMATCH), exp_mm);

        @(negedge CLK);
        check_output("done_pulse", int'(DONE), 0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int done_pulses;
        logic [1:0] rop;
        int rlen;

        vecs[0] = '{OP_LD,   4'hA, 0,  1'b0, 4'hA};
        vecs[1] = '{OP_LD,   4'hE, 0,  1'b0, 4'hE};
        vecs[2] = '{OP_UP,   4'h0, 3,  1'b0, 4'h1};
        vecs[3] = '{OP_LD,   4'h1, 0,  1'b0, 4'h1};
        vecs[4] = '{OP_DN,   4'h0, 2,  1'b0, 4'hF};
        vecs[5] = '{OP_HOLD, 4'h0, 4,  1'b1, 4'hF};
        vecs[6] = '{OP_UP,   4'h0, 0,  1'b1, 4'hF};
        vecs[7] = '{OP_DN,   4'h0, 0,  1'b0, 4'hF};
        vecs[8] = '{OP_UP,   4'h0, 16, 1'b1, 4'hF};
        vecs[9] = '{OP_DN,   4'h0, 5,  1'b0, 4'hA};

        RSTB      = 1'b0;
        CMD_VALID = 1'b0;
        CMD_OP    = OP_LD;
        CMD_DATA  = 4'd0;
        CMD_LEN   = 8'd0;
        repeat (3) @(negedge CLK);
        check_reset_values();
        RSTB = 1'b1;
        @(negedge CLK);
        check_output("rel_ready", int'(CMD_READY), 1);
        check_output("rel_done", int'(DONE), 0);

        $display("[TB] table vectors");
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(vecs[i].op, vecs[i].data, vecs[i].len, vecs[i].junk, 0);
            check_output("table_exp", int'(EXP), int'(vecs[i].exp_final));
        end

        $display("[TB] sticky mismatch through HOLD");
        apply_stimulus(OP_LD, 4'h4, 0, 1'b0, 0);
        force_val = 4'h3;
        force_q   = 1'b1;
        @(negedge CLK);
        check_output("mm_set", int'(MISMATCH), 1);
        apply_stimulus(OP_HOLD, 4'h0, 5, 1'b0, 1);
        force_q = 1'b0;
        @(negedge CLK);
        check_output("mm_sticky", int'(MISMATCH), 1);
        apply_stimulus(OP_LD, 4'h7, 0, 1'b0, 0);

        $display("[TB] mismatch on the LOAD accept edge");
        force_val = 4'h3;
        force_q   = 1'b1;
        CMD_VALID = 1'b1;
        CMD_OP    = OP_LD;
        CMD_DATA  = 4'h9;
        CMD_LEN   = 8'd0;
        @(negedge CLK);
        check_output("mm_prio", int'(MISMATCH), 1);
        check_output("mm_prio_loadb", int'(LOADB), 0);
        CMD_VALID = 1'b0;
        force_q   = 1'b0;
        @(negedge CLK);
        check_output("mm_prio_done", int'(DONE), 1);
        check_output("mm_prio_sticky", int'(MISMATCH), 1);
        check_output("mm_prio_exp", int'(EXP), 9);
        @(negedge CLK);
        model_exp = 9;
        model_a   = 9;
        apply_stimulus(OP_LD, 4'h2, 0, 1'b0, 0);

        $display("[TB] reset during UP");
        CMD_VALID = 1'b1;
        CMD_OP    = OP_UP;
        CMD_DATA  = 4'h0;
        CMD_LEN   = 8'd10;
        @(negedge CLK);
        CMD_VALID = 1'b0;
        force_val = 4'hC;
        force_q   = 1'b1;
        repeat (3) @(negedge CLK);
        check_output("mid_entb", int'(ENTB), 0);
        check_output("mid_mm", int'(MISMATCH), 1);
        RSTB    = 1'b0;
        force_q = 1'b0;
        @(negedge CLK);
        check_reset_values();
        RSTB = 1'b1;
        @(negedge CLK);
        check_output("post_rst_ready", int'(CMD_READY), 1);
        done_pulses = 0;
        for (int i = 0; i < 12; i++) begin
            if (DONE) done_pulses++;
            @(negedge CLK);
        end
        check_output("post_rst_no_done", done_pulses, 0);
        model_exp = 0;
        model_a   = 0;

        $display("[TB] random commands");
        apply_stimulus(OP_LD, 4'($urandom), 0, 1'b0, 0);
        for (int i = 0; i < 40; i++) begin
            rop  = 2'($urandom_range(0, 3));
            rlen = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 20));
            apply_stimulus(rop, 4'($urandom), rlen, 1'($urandom_range(0, 1)), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
